// File: rtl/ras_ckpt.sv
// rtl/ras_ckpt.sv - checkpointable return address stack for fetch-stage return prediction
// Top entry and checkpoint token are driven straight from registers; restore rewrites the top entry.
module ras_ckpt #(
  parameter int RAS_DEPTH  = 8,
  parameter int ADDR_WIDTH = 30,
  parameter int PTR_W      = $clog2(RAS_DEPTH),
  parameter int CNT_W      = $clog2(RAS_DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push_valid,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  pop_valid,
  output logic                  top_valid,
  output logic [ADDR_WIDTH-1:0] top_addr,
  output logic [PTR_W-1:0]      ckpt_ptr,
  output logic [CNT_W-1:0]      ckpt_count,
  output logic [ADDR_WIDTH-1:0] ckpt_top,
  input  logic                  restore_valid,
  input  logic [PTR_W-1:0]      restore_ptr,
  input  logic [CNT_W-1:0]      restore_count,
  input  logic [ADDR_WIDTH-1:0] restore_top,
  output logic [7:0]            overflow_cnt
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_WIDTH-1:0] r_entry [RAS_DEPTH];
  logic [PTR_W-1:0]      r_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [7:0]            r_ovf;

  logic [PTR_W-1:0]      w_ptr_inc;
  logic [PTR_W-1:0]      w_ptr_dec;
  logic                  w_empty;
  logic                  w_full;

  assign w_ptr_inc = r_ptr + PTR_W'(1);
  assign w_ptr_dec = r_ptr - PTR_W'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_entry[i] <= '0;
      end
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= '0;
    end else if (restore_valid) begin
      r_ptr                <= restore_ptr;
      r_count              <= restore_count;
      r_entry[restore_ptr] <= restore_top;
    end else if (push_valid && pop_valid && !w_empty) begin
      // Linking return: the return consumes the top, the call replaces it in place.
      r_entry[r_ptr] <= push_addr;
    end else if (push_valid) begin
      r_ptr              <= w_ptr_inc;
      r_entry[w_ptr_inc] <= push_addr;
      if (w_full) begin
        if (r_ovf != 8'hFF) begin
          r_ovf <= r_ovf + 8'd1;
        end
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (pop_valid && !w_empty) begin
      r_ptr   <= w_ptr_dec;
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign top_valid    = !w_empty;
  assign top_addr     = r_entry[r_ptr];
  assign ckpt_ptr     = r_ptr;
  assign ckpt_count   = r_count;
  assign ckpt_top     = r_entry[r_ptr];
  assign overflow_cnt = r_ovf;

endmodule

// File: doc/ras_ckpt.md
# ras_ckpt

Parametrised, checkpointable return address stack for the fetch stage. It supplies a zero-latency return-target prediction from its registered top entry, and accepts push (call) and pop (return) updates. It exports a compact snapshot token that the core attaches to each predicted branch. Presenting that token back on a misprediction repairs the stack, including a top entry clobbered by a wrong-path push.

## Interface
- RAS_DEPTH, 8: number of entries; power of two, ≥ 2.
- ADDR_WIDTH, 30: width of a stored return address (word PC).
- PTR_W, $clog2(RAS_DEPTH): pointer width (derived; do not override).
- CNT_W, $clog2(RAS_DEPTH)+1: occupancy width (derived; do not override).

Ports. One clock, CLK. Reset RST is asynchronous and active-high.
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  asynchronous, active-high reset.
- push_valid  in  1  call fetched; push push_addr.
- push_addr  in  ADDR_WIDTH  return address (call PC + 1).
- pop_valid  in  1  return fetched; pop top.
- top_valid  out  1  stack non-empty (count != 0).
- top_addr  out  ADDR_WIDTH  entry[ptr]; predicted return target.
- ckpt_ptr  out  PTR_W  current ptr.
- ckpt_count  out  CNT_W  current count.
- ckpt_top  out  ADDR_WIDTH  current entry[ptr].
- restore_valid  in  1  misprediction repair.
- restore_ptr  in  PTR_W  ptr to restore.
- restore_count  in  CNT_W  count to restore (≤ RAS_DEPTH).
- restore_top  in  ADDR_WIDTH  value rewritten into entry[restore_ptr].
- overflow_cnt  out  8  saturating count of pushes that overwrote a live entry.

## Operation
- State:
  - entry[0..RAS_DEPTH-1] (circular);
  - ptr, which indexes the top entry;
  - count, saturating at RAS_DEPTH;
  - overflow_cnt.
- Priority each cycle is restore > push+pop > push > pop > idle.
- Restore: ptr←restore_ptr, count←restore_count, entry[restore_ptr]←restore_top. Any push/pop in the same cycle is dropped.
- Push only: ptr←ptr+1 mod RAS_DEPTH, entry[ptr+1]←push_addr, count←min(count+1, RAS_DEPTH). If count==RAS_DEPTH before the push, the oldest entry is overwritten and overflow_cnt increments, saturating at 255.
- Pop only:
  - If count>0: ptr←ptr−1 mod RAS_DEPTH, count←count−1. The popped entry's contents are left in place.
  - If count==0: no state change. Fetch must ignore top_addr because top_valid=0.
- Push+pop in the same cycle (a linking return):
  - If count>0: entry[ptr]←push_addr; ptr and count are unchanged.
  - If count==0: behaves as push only.
- Pointer arithmetic wraps modulo RAS_DEPTH; no carry out is kept.
- count never exceeds RAS_DEPTH and never goes below 0.

## Timing
- top_valid, top_addr, ckpt_* and overflow_cnt are combinational from registers only. No input-to-output combinational path exists.
- Update latency is 1 cycle: an operation presented in cycle N is visible on the outputs in cycle N+1.
- Prediction: fetch samples top_addr in the same cycle it asserts pop_valid (read-before-pop).
- Checkpoint: sample ckpt_* in the cycle the branch is predicted, before that cycle's own push/pop takes effect.
- Reset: asynchronously, all outputs go to 0. That means ptr=0, count=0, every entry=0, top_valid=0, top_addr=0, ckpt_ptr=0, ckpt_count=0, ckpt_top=0, overflow_cnt=0. Reset asserted mid-operation discards any in-flight push/pop/restore.
- Back-to-back operations every cycle are supported; no stalls and no ready signal.

## Test plan
All scenarios use RAS_DEPTH=4 and ADDR_WIDTH=30.
- Reset, then idle → top_valid=0 and all outputs 0. Pop with empty stack → state unchanged, count=0.
- Push 0x100, 0x200, 0x300; then pop twice, sampling before each pop → top_addr=0x300, then 0x200. Final count=1, top_addr=0x100.
- Push 0x1..0x5, i.e. 5 pushes → count=4, overflow_cnt=1, top_addr=0x5. Four pops yield 0x5, 0x4, 0x3, 0x2. After that, top_valid=0.
- After pushes 0xA, 0xB, capture ckpt (ptr=2, count=2, top=0xB). Then pop and push 0xEE, so entry[2]=0xEE. Restore with the token → top_addr=0xB, count=2. Two pops yield 0xB, then 0xA.
- Push+pop in the same cycle with count=2, top=0xB, push_addr=0xC → top_addr=0xC, count=2, ptr unchanged. Repeat with count=0 → count=1, top_addr=0xC.
- Restore together with push in the same cycle → push ignored and state equals the token. Assert RST mid-sequence → all outputs 0 immediately, with no dependence on CLK.
